// File: rtl/regbank_arbiter.sv
// Two-port arbiter/sequencer for a single-port 8x16 register bank with level-sensitive load.
// Each transaction is granted in IDLE and retired with a one-cycle ack in DONE.
module regbank_arbiter #(
    parameter int DATA_W = 16,
    parameter int ID_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ID_W-1:0]   id0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ID_W-1:0]   id1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ID_W-1:0]   bank_rId,
    output logic [DATA_W-1:0] bank_rIn,
    output logic              bank_ldR,
    input  logic [DATA_W-1:0] bank_rOut
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        HOLD,
        SAMPLE,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic                last_q;
    logic                owner_q;
    logic                we_q;
    logic [ID_W-1:0]     id_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                grantValid_d;
    logic                grantPort_d;

    // Grant decision and sequencing; on a tie the port that did not win last time gets the bank.
    always_comb begin
        state_d      = state_q;
        grantValid_d = 1'b0;
        grantPort_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    grantValid_d = 1'b1;
                    grantPort_d  = ~last_q;
                end else if (req0) begin
                    grantValid_d = 1'b1;
                    grantPort_d  = 1'b0;
                end else if (req1) begin
                    grantValid_d = 1'b1;
                    grantPort_d  = 1'b1;
                end
                if (grantValid_d) begin
                    state_d = SETUP;
                end
            end
            SETUP:   state_d = we_q ? LOAD : SAMPLE;
            LOAD:    state_d = HOLD;
            HOLD:    state_d = DONE;
            SAMPLE:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // id_q/wdata_q drive the bank directly, so they double as the stable setup/hold values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            id_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grantValid_d) begin
                owner_q <= grantPort_d;
                last_q  <= grantPort_d;
                we_q    <= grantPort_d ? we1 : we0;
                id_q    <= grantPort_d ? id1 : id0;
                if (grantPort_d ? we1 : we0) begin
                    wdata_q <= grantPort_d ? wdata1 : wdata0;
                end
            end
            if (state_q == SAMPLE) begin
                rdata_q <= bank_rOut;
            end
        end
    end

    assign bank_rId = id_q;
    assign bank_rIn = wdata_q;
    assign bank_ldR = (state_q == LOAD);
    assign ack0     = (state_q == DONE) && !owner_q;
    assign ack1     = (state_q == DONE) && owner_q;
    assign busy     = (state_q != IDLE);
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed bench for regbank_arbiter with a behavioural 8x16 register bank on its bank port.
module tb_regbank_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, we0, ack0;
    logic [2:0]  id0;
    logic [15:0] wdata0;
    logic        req1, we1, ack1;
    logic [2:0]  id1;
    logic [15:0] wdata1;
    logic [15:0] rdata;
    logic        busy;
    logic [2:0]  bank_rId;
    logic [15:0] bank_rIn;
    logic        bank_ldR;
    logic [15:0] bank_rOut;

    logic [15:0] bankMem [8];

    int testCount = 0;
    int failCount = 0;

    regbank_arbiter #(.DATA_W(16), .ID_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .we0       (we0),
        .id0       (id0),
        .wdata0    (wdata0),
        .ack0      (ack0),
        .req1      (req1),
        .we1       (we1),
        .id1       (id1),
        .wdata1    (wdata1),
        .ack1      (ack1),
        .rdata     (rdata),
        .busy      (busy),
        .bank_rId  (bank_rId),
        .bank_rIn  (bank_rIn),
        .bank_ldR  (bank_ldR),
        .bank_rOut (bank_rOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model: combinational read, write while the load enable is high at a clock edge.
    always @(posedge clk) begin
        if (bank_ldR) begin
            bankMem[bank_rId] <= bank_rIn;
        end
    end
    assign bank_rOut = bankMem[bank_rId];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one transaction from IDLE and checks latency, load pulse count, bank stability and rdata.
    task automatic applyStimulus(input int port, input logic we, input logic [2:0] id,
                                 input logic [15:0] wd, input logic [15:0] expRd);
        int cyc = 0;
        int ldrCount = 0;
        bit gotAck = 0;
        bit stableOk = 1;
        bit otherOk = 1;
        logic ackMine, ackOther;
        if (port == 0) begin
            req0 = 1'b1; we0 = we; id0 = id; wdata0 = wd;
        end else begin
            req1 = 1'b1; we1 = we; id1 = id; wdata1 = wd;
        end
        while (!gotAck && cyc < 20) begin
            tick();
            cyc++;
            if (bank_ldR) ldrCount++;
            ackMine  = (port == 0) ? ack0 : ack1;
            ackOther = (port == 0) ? ack1 : ack0;
            if (ackOther) otherOk = 0;
            if (ackMine) begin
                gotAck = 1;
            end else if (bank_rId !== id || (we && bank_rIn !== wd)) begin
                stableOk = 0;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        checkOutput($sformatf("ack seen p%0d id%0d", port, id), 32'(gotAck), 32'd1);
        checkOutput($sformatf("latency p%0d id%0d", port, id), 32'(cyc), we ? 32'd4 : 32'd3);
        checkOutput($sformatf("ldR pulses p%0d id%0d", port, id), 32'(ldrCount), we ? 32'd1 : 32'd0);
        checkOutput($sformatf("bank stable p%0d id%0d", port, id), 32'(stableOk), 32'd1);
        checkOutput($sformatf("other ack quiet p%0d id%0d", port, id), 32'(otherOk), 32'd1);
        if (!we) begin
            checkOutput($sformatf("rdata p%0d id%0d", port, id), 32'(rdata), 32'(expRd));
        end
        tick();
        checkOutput($sformatf("idle after p%0d id%0d", port, id), 32'(busy), 32'd0);
    endtask

    initial begin
        int ackOrder [4];
        int nAcks;
        int cyc;
        int ack0Count;
        bit dropOk;

        reset = 1'b0;
        req0 = 1'b0; we0 = 1'b0; id0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; id1 = '0; wdata1 = '0;
        tick();
        tick();
        checkOutput("reset ack0", 32'(ack0), 32'd0);
        checkOutput("reset ack1", 32'(ack1), 32'd0);
        checkOutput("reset ldR", 32'(bank_ldR), 32'd0);
        checkOutput("reset rId", 32'(bank_rId), 32'd0);
        checkOutput("reset rIn", 32'(bank_rIn), 32'd0);
        checkOutput("reset rdata", 32'(rdata), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick();

        applyStimulus(0, 1'b1, 3'd3, 16'hA5C3, 16'h0000);
        applyStimulus(1, 1'b0, 3'd3, 16'h0000, 16'hA5C3);

        // Simultaneous requests right after reset: port 0 first, then strict alternation.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req0 = 1'b1; we0 = 1'b0; id0 = 3'd0;
        req1 = 1'b1; we1 = 1'b0; id1 = 3'd1;
        nAcks = 0;
        cyc = 0;
        while (nAcks < 3 && cyc < 40) begin
            tick();
            cyc++;
            if (ack0 && nAcks < 4) begin ackOrder[nAcks] = 0; nAcks++; end
            if (ack1 && nAcks < 4) begin ackOrder[nAcks] = 1; nAcks++; end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        checkOutput("fair ack count", 32'(nAcks), 32'd3);
        checkOutput("fair first", 32'(ackOrder[0]), 32'd0);
        checkOutput("fair second", 32'(ackOrder[1]), 32'd1);
        checkOutput("fair third", 32'(ackOrder[2]), 32'd0);
        tick();
        checkOutput("fair idle", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(i % 2, 1'b1, 3'(i), 16'(16'h1111 * i), 16'h0000);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus((i + 1) % 2, 1'b0, 3'(i), 16'h0000, 16'(16'h1111 * i));
        end

        // Reset during LOAD of a write aborts without an ack and clears rdata.
        req0 = 1'b1; we0 = 1'b1; id0 = 3'd5; wdata0 = 16'hBEEF;
        tick();
        tick();
        checkOutput("in LOAD ldR", 32'(bank_ldR), 32'd1);
        reset = 1'b0;
        req0 = 1'b0;
        tick();
        checkOutput("abort ldR", 32'(bank_ldR), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort ack0", 32'(ack0), 32'd0);
        checkOutput("abort rdata", 32'(rdata), 32'd0);
        reset = 1'b1;
        tick();
        checkOutput("post abort ack0", 32'(ack0), 32'd0);
        applyStimulus(1, 1'b0, 3'd2, 16'h0000, 16'h2222);

        // Request dropped and operands changed right after grant: captured values still apply.
        req0 = 1'b1; we0 = 1'b1; id0 = 3'd6; wdata0 = 16'hABCD;
        tick();
        req0 = 1'b0; id0 = 3'd1; wdata0 = 16'h0000;
        ack0Count = 0;
        dropOk = 1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (ack0) ack0Count++;
            if (bank_ldR && (bank_rId !== 3'd6 || bank_rIn !== 16'hABCD)) dropOk = 0;
        end
        checkOutput("drop ack0 once", 32'(ack0Count), 32'd1);
        checkOutput("drop captured values", 32'(dropOk), 32'd1);
        checkOutput("drop idle", 32'(busy), 32'd0);
        applyStimulus(1, 1'b0, 3'd6, 16'h0000, 16'hABCD);
        applyStimulus(0, 1'b0, 3'd1, 16'h0000, 16'h1111);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/regbank_arbiter.md
Name: regbank_arbiter

Overview:
- Sequencer and arbiter that shares the single-port 8x16 register bank between two requesters (port 0: stack/operand unit, port 1: writeback unit).
- Converts per-requester read/write requests into the bank's rId/rIn/ldR signalling, with setup and hold around the level-sensitive load.
- Captures read data from the bank's combinational output and returns it with a one-cycle ack.

Parameters:
- DATA_W, 16, bank data width (rIn/rOut).
- ID_W, 3, register index width (8 registers).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- req0  input  1  port 0 request; hold high until ack0.
- we0  input  1  port 0 request type: 1 = write, 0 = read.
- id0  input  ID_W  port 0 register index.
- wdata0  input  DATA_W  port 0 write data.
- ack0  output  1  port 0 completion pulse, one cycle.
- req1, we1, id1, wdata1, ack1  port 1 equivalents of the above.
- rdata  output  DATA_W  data of the last completed read; valid in the ack cycle of a read.
- busy  output  1  high when state is not IDLE.
- bank_rId  output  ID_W  to bank rId.
- bank_rIn  output  DATA_W  to bank rIn.
- bank_ldR  output  1  to bank ldR; level-sensitive load enable.
- bank_rOut  input  DATA_W  from bank rOut; combinational read data.

Behaviour:
- All outputs are registered or decoded from registered state. There is no combinational path from req*/id*/wdata* to bank_* outputs.
- Reset (reset=0 at a rising edge):
  - state=IDLE, last=1 so port 0 wins the first tie.
  - ack0=ack1=0, bank_ldR=0, bank_rId=0, bank_rIn=0, rdata=0, busy=0.
- Reset mid-transaction: the same edge forces bank_ldR=0 and state=IDLE, and no ack is issued. The target register may hold partial or new data; the requester must reissue.
- States: IDLE, SETUP, LOAD, HOLD, SAMPLE, DONE.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If exactly one reqN=1, grant N.
  - If both requests are high, grant the port not equal to last.
  - On grant, capture owner, we, id, and wdata into internal registers, set last=owner, and go to SETUP.
- SETUP: bank_rId=id_q, bank_rIn=wdata_q (write) or held value (read), bank_ldR=0. Next state is LOAD if we_q=1, otherwise SAMPLE.
- LOAD: bank_ldR=1; rId and rIn unchanged. Next state is HOLD.
- HOLD: bank_ldR=0; rId and rIn unchanged, providing hold time. Next state is DONE.
- SAMPLE: rdata <= bank_rOut at the end of the cycle. Next state is DONE.
- DONE: ack[owner]=1 for exactly this cycle; rdata is valid if the transaction was a read. Next state is IDLE, unconditionally.
- bank_rId and bank_rIn keep their last value in IDLE and DONE. bank_ldR is high only in LOAD.
- Latency, from the IDLE cycle that grants:
  - write: ack 4 cycles later (IDLE, SETUP, LOAD, HOLD, DONE).
  - read: ack 3 cycles later (IDLE, SETUP, SAMPLE, DONE).
  - Throughput: one write per 5 cycles, one read per 4 cycles.
- Requester rules:
  - Hold req until the ack edge, then drop it (registered).
  - If req is still high in the following IDLE cycle, it is treated as a new request.
  - id, we, and wdata are sampled only at grant, so later changes are ignored.
  - Dropping req before ack does not abort; the transaction completes and ack still pulses.
- rdata changes only in SAMPLE. A write does not alter rdata.
- Fairness: under continuous requests on both ports, grants alternate 0,1,0,1,… No starvation; worst-case wait is one other transaction.
- A read of a register written by the immediately preceding transaction returns the new value, because the load completes before DONE.

Test Plan:
- Reset, then port 0 writes id0=3, wdata0=16'hA5C3. Required: bank_ldR high in exactly 1 cycle with bank_rId=3 and bank_rIn=A5C3 stable from SETUP through HOLD; ack0 4 cycles after grant.
- Port 1 reads id1=3 right after that write. Required: rdata=16'hA5C3 and ack1 3 cycles after grant; ack0 stays 0.
- req0 and req1 asserted in the same cycle after reset, both held. Required: port 0 served first, then port 1, then port 0 (alternation); ack order 0,1,0.
- Write all 8 registers with value 16'h1111*i via alternating ports, then read all 8. Required: each rdata=16'h1111*i; id 7 wraps correctly; bank_ldR never high outside LOAD.
- Assert reset low during the LOAD state of a write. Required: next edge gives bank_ldR=0, busy=0, no ack, rdata=0; a subsequent request is served normally.
- req0 dropped one cycle after grant, with id0/wdata0 changed. Required: the transaction completes with the captured values, and ack0 still pulses once.
